// File: rtl/uart_rx_param_if.sv
// Consumer-side bundle of the parametrised UART receiver: the receive FIFO
// head (data plus per-frame flags), the pop/clear strobes, and the status bits.
interface uart_rx_param_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 rdy;
  logic [DATA_BITS-1:0] cmd;
  logic                 frm_err;
  logic                 par_err;
  logic                 ovr_err;
  logic                 busy;
  logic                 clr_rdy;
  logic                 clr_err;

  // Receiver side: presents the FIFO head and status, takes the strobes.
  modport master (
    output rdy, cmd, frm_err, par_err, ovr_err, busy,
    input  clr_rdy, clr_err
  );

  // Consumer side: reads the head and status, issues pop/clear strobes.
  modport slave (
    input  rdy, cmd, frm_err, par_err, ovr_err, busy,
    output clr_rdy, clr_err
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: two-flop RX synchroniser, mid-bit sampling FSM
// with false-start rejection, optional parity, 1/2 stop bits, break handling,
// and a small receive FIFO with a sticky overrun flag.
module uart_rx_param #(
  parameter int unsigned CLK_DIV    = 108,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               RX,
  uart_rx_param_if.master    bus
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam int unsigned ENT_W = DATA_BITS + 2;

  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic             ODD       = 1'(PARITY_ODD);
  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  // Synchroniser
  logic rx_m, rx_s;

  // Frame FSM
  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [BIT_W-1:0]     bit_idx, bit_nxt;
  logic                 stop_idx, stop_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 frm_acc, frm_nxt;
  logic                 par_acc, par_nxt;
  logic                 sample;
  logic                 push;

  // FIFO
  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [OCC_W-1:0] count;
  logic             ovr;
  logic             full, pop, wr_en, ovr_set;
  logic [ENT_W-1:0] head;

  // Two-flop synchroniser, idle-high reset so no spurious start after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= RX;
      rx_s <= rx_m;
    end
  end

  // FSM and frame datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      frm_acc  <= 1'b0;
      par_acc  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bit_idx  <= bit_nxt;
      stop_idx <= stop_nxt;
      shreg    <= shreg_nxt;
      frm_acc  <= frm_nxt;
      par_acc  <= par_nxt;
    end
  end

  assign sample = (cnt == '0);

  // Next-state, bit sampling and push generation.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = sample ? cnt : cnt - 1'b1;
    bit_nxt   = bit_idx;
    stop_nxt  = stop_idx;
    shreg_nxt = shreg;
    frm_nxt   = frm_acc;
    par_nxt   = par_acc;
    push      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!rx_s) begin
          state_nxt = S_START;
          cnt_nxt   = CNT_HALF;
        end
      end
      S_START: begin
        if (sample) begin
          if (rx_s) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_DATA;
            cnt_nxt   = CNT_FULL;
            bit_nxt   = '0;
            frm_nxt   = 1'b0;
            par_nxt   = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (sample) begin
          shreg_nxt = {rx_s, shreg[DATA_BITS-1:1]};
          cnt_nxt   = CNT_FULL;
          bit_nxt   = bit_idx + 1'b1;
          if (bit_idx == BIT_LAST) begin
            state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            stop_nxt  = 1'b0;
          end
        end
      end
      S_PARITY: begin
        if (sample) begin
          par_nxt   = ((^shreg) ^ rx_s) != ODD;
          cnt_nxt   = CNT_FULL;
          state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (sample) begin
          cnt_nxt = CNT_FULL;
          if (!rx_s) frm_nxt = 1'b1;
          if (stop_idx == STOP_LAST) begin
            push      = 1'b1;
            state_nxt = rx_s ? S_IDLE : S_BREAK;
          end else begin
            stop_nxt = stop_idx + 1'b1;
          end
        end
      end
      S_BREAK: begin
        if (rx_s) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FIFO control: a pop frees a slot in the same cycle, so push-on-full
  // with a coincident pop is accepted rather than counted as an overrun.
  assign full    = (count == OCC_FULL);
  assign pop     = bus.clr_rdy && (count != '0);
  assign wr_en   = push && (!full || pop);
  assign ovr_set = push && full && !pop;

  // FIFO storage; only the written slot changes.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {shreg_nxt, frm_nxt, par_nxt};
  end

  // FIFO pointers, occupancy and sticky overrun (set wins over clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovr    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovr_set)          ovr <= 1'b1;
      else if (bus.clr_err) ovr <= 1'b0;
    end
  end

  // Head entry is masked while empty so outputs read zero after reset.
  assign head        = mem[rd_ptr];
  assign bus.rdy     = (count != '0);
  assign bus.cmd     = bus.rdy ? head[ENT_W-1:2] : '0;
  assign bus.frm_err = bus.rdy ? head[1] : 1'b0;
  assign bus.par_err = bus.rdy ? head[0] : 1'b0;
  assign bus.ovr_err = ovr;
  assign bus.busy    = (state != S_IDLE);

endmodule
